spi_frame_loader: RTL and testbench



---
 rtl/ledsuit_pkg.sv | 18 +
 rtl/async_input_sync.sv | 45 ++++
 rtl/spi_frame_loader.sv | 206 ++++++++++++++++++++
 tb/tb_spi_frame_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ledsuit_pkg.sv
// Shared constants and loader state encoding for the LED suit.
// Channel memory is NUM_LEDS * 3 bytes, addressed by a 13-bit bus.
package ledsuit_pkg;

  localparam int NUM_LEDS         = 72;
  localparam int CHANNELS_PER_LED = 3;
  localparam int NUM_CHANNELS     = NUM_LEDS * CHANNELS_PER_LED;
  localparam int CHAN_ADDR_WIDTH  = 13;

  typedef logic [2:0] loader_state_t;

  localparam loader_state_t ST_WAIT_CS_HIGH = 3'd0;
  localparam loader_state_t ST_IDLE         = 3'd1;
  localparam loader_state_t ST_ADDR_HI      = 3'd2;
  localparam loader_state_t ST_ADDR_LO      = 3'd3;
  localparam loader_state_t ST_DATA         = 3'd4;

endpackage

// File: rtl/async_input_sync.sv
// Two-flop synchroniser with a third flop for edge detection.
// Edge pulses are registered, so they lag the level by one cycle.
module async_input_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync2_q, sync3_q, rise_q, fall_q;
  logic sync1_d, sync2_d, sync3_d, rise_d, fall_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    rise_d  = sync2_q & ~sync3_q;
    fall_d  = ~sync2_q & sync3_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      sync3_q <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = sync2_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_frame_loader.sv
// SPI mode-0 slave that writes addressed channel bytes into LED memory.
// Frame: addr_hi, addr_lo, then data bytes at auto-incrementing addresses.
module spi_frame_loader
  import ledsuit_pkg::*;
#(
  parameter int MAX_CHANNELS = NUM_CHANNELS,
  parameter int ADDR_WIDTH   = CHAN_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  input  logic                  spi_cs_n,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [7:0]            mem_wr_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  frame_error
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MAX_CHANNELS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX   = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic unused_edges;

  async_input_sync #(.RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .din(spi_sck),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  async_input_sync #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .din(spi_mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  async_input_sync #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .din(spi_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  assign unused_edges = ^{sck_lvl, sck_fall, mosi_rise, mosi_fall};

  loader_state_t         state_q, state_d;
  logic [1:0]            wait_cnt_q, wait_cnt_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [6:0]            shift_q, shift_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  written_q, written_d;
  logic                  wr_req_q, wr_req_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [7:0]            req_data_q, req_data_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0] mem_wr_addr_q, mem_wr_addr_d;
  logic [7:0]            mem_wr_data_q, mem_wr_data_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overflow_q, overflow_d;
  logic                  frame_error_q, frame_error_d;

  logic       active;
  logic       sck_ev;
  logic       byte_done;
  logic [7:0] byte_new;

  always_comb begin
    active    = (state_q == ST_ADDR_HI) || (state_q == ST_ADDR_LO) ||
                (state_q == ST_DATA);
    sck_ev    = active && sck_rise;
    byte_new  = {shift_q, mosi_lvl};
    byte_done = sck_ev && (bit_cnt_q == 3'd7);

    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    addr_d        = addr_q;
    written_d     = written_q;
    wr_req_d      = 1'b0;
    req_addr_d    = req_addr_q;
    req_data_d    = req_data_q;
    frame_done_d  = 1'b0;
    overflow_d    = overflow_q;
    frame_error_d = frame_error_q;

    if (sck_ev) begin
      shift_d   = byte_new[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    case (state_q)
      ST_WAIT_CS_HIGH: begin
        // CS sync flops reset high, so require CS to stay high long
        // enough that a still-low pin has had time to show through.
        if (!cs_lvl) begin
          wait_cnt_d = 2'd0;
        end else if (wait_cnt_q != 2'd3) begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (cs_fall) begin
          state_d       = ST_ADDR_HI;
          bit_cnt_d     = 3'd0;
          overflow_d    = 1'b0;
          frame_error_d = 1'b0;
          written_d     = 1'b0;
        end
      end
      ST_ADDR_HI: begin
        if (byte_done) begin
          addr_d  = {byte_new[ADDR_WIDTH-9:0], addr_q[7:0]};
          state_d = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (byte_done) begin
          addr_d  = {addr_q[ADDR_WIDTH-1:8], byte_new};
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (byte_done) begin
          if (addr_q < ADDR_LIMIT) begin
            wr_req_d   = 1'b1;
            req_addr_d = addr_q;
            req_data_d = byte_new;
            written_d  = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
          if (addr_q != ADDR_MAX) addr_d = addr_q + ADDR_ONE;
        end
      end
      default: state_d = ST_WAIT_CS_HIGH;
    endcase

    // Uses the _d values so a byte finishing on the CS rise still counts.
    if (active && cs_rise) begin
      state_d       = ST_IDLE;
      frame_error_d = (bit_cnt_d != 3'd0);
      frame_done_d  = written_d;
    end

    busy_d = (state_d == ST_ADDR_HI) || (state_d == ST_ADDR_LO) ||
             (state_d == ST_DATA);

    mem_wr_en_d   = wr_req_q;
    mem_wr_addr_d = wr_req_q ? req_addr_q : mem_wr_addr_q;
    mem_wr_data_d = wr_req_q ? req_data_q : mem_wr_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_WAIT_CS_HIGH;
      wait_cnt_q    <= 2'd0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 7'd0;
      addr_q        <= '0;
      written_q     <= 1'b0;
      wr_req_q      <= 1'b0;
      req_addr_q    <= '0;
      req_data_q    <= 8'd0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= 8'd0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      addr_q        <= addr_d;
      written_q     <= written_d;
      wr_req_q      <= wr_req_d;
      req_addr_q    <= req_addr_d;
      req_data_q    <= req_data_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_spi_frame_loader.sv
// Scoreboard bench for spi_frame_loader: expected writes are queued
// as frames are driven and popped when the write strobe appears.
module tb_spi_frame_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sck, spi_mosi, spi_cs_n;
  logic        mem_wr_en;
  logic [12:0] mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic        busy, frame_done, overflow, frame_error;

  spi_frame_loader dut (
    .clk(clk), .rst(rst),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .busy(busy),
    .frame_done(frame_done), .overflow(overflow),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t  exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   wr_cnt   = 0;
  int   fd_cnt   = 0;
  logic prev_en  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int a, input int d);
    wr_t e;
    e.a = 13'(a);
    e.d = 8'(d);
    exp_q.push_back(e);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      repeat (4) @(negedge clk);
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (mem_wr_en) begin
      wr_t e;
      wr_cnt++;
      chk("wr_width", 32'(prev_en), 32'd0);
      if (exp_q.size() == 0) begin
        chk("wr_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_wr_addr), 32'(e.a));
        chk("wr_data", 32'(mem_wr_data), 32'(e.d));
      end
    end
    if (frame_done) fd_cnt++;
    prev_en = mem_wr_en;
  end

  int         fd0, wr0;
  logic [5:0] en_seen;

  initial begin
    rst      = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_en",   32'(mem_wr_en),   32'd0);
    chk("rst_addr", 32'(mem_wr_addr), 32'd0);
    chk("rst_data", 32'(mem_wr_data), 32'd0);
    chk("rst_busy", 32'(busy),        32'd0);
    chk("rst_fd",   32'(frame_done),  32'd0);
    chk("rst_ovf",  32'(overflow),    32'd0);
    chk("rst_ferr", 32'(frame_error), 32'd0);
    repeat (10) @(negedge clk);

    // three bytes from address 0
    fd0 = fd_cnt;
    push(0, 8'hAA); push(1, 8'h55); push(2, 8'h0F);
    cs_low();
    chk("t1_busy", 32'(busy), 32'd1);
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0F);
    cs_high();
    chk("t1_left", 32'(exp_q.size()), 32'd0);
    chk("t1_fd",   32'(fd_cnt - fd0), 32'd1);
    chk("t1_ovf",  32'(overflow),     32'd0);
    chk("t1_ferr", 32'(frame_error),  32'd0);
    chk("t1_idle", 32'(busy),         32'd0);

    // run past the end of channel memory
    fd0 = fd_cnt;
    push(214, 8'h11); push(215, 8'h22);
    cs_low();
    send_byte(8'h00); send_byte(8'hD6);
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    cs_high();
    chk("t2_left", 32'(exp_q.size()), 32'd0);
    chk("t2_fd",   32'(fd_cnt - fd0), 32'd1);
    chk("t2_ovf",  32'(overflow),     32'd1);

    // top of address space: nothing written, address saturates
    fd0 = fd_cnt;
    wr0 = wr_cnt;
    cs_low();
    chk("t3_ovf_clr", 32'(overflow), 32'd0);
    send_byte(8'hFF); send_byte(8'hFF);
    send_byte(8'h01); send_byte(8'h02);
    cs_high();
    chk("t3_wr",   32'(wr_cnt - wr0), 32'd0);
    chk("t3_fd",   32'(fd_cnt - fd0), 32'd0);
    chk("t3_ovf",  32'(overflow),     32'd1);
    chk("t3_hold", 32'(mem_wr_addr),  32'd215);

    // partial trailing byte
    fd0 = fd_cnt;
    push(16, 8'h12);
    cs_low();
    send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h12); send_bits(8'hA0, 3);
    cs_high();
    chk("t4_left", 32'(exp_q.size()), 32'd0);
    chk("t4_fd",   32'(fd_cnt - fd0), 32'd1);
    chk("t4_ferr", 32'(frame_error),  32'd1);
    chk("t4_ovf",  32'(overflow),     32'd0);

    push(32, 8'h77);
    cs_low();
    chk("t4_ferr_clr", 32'(frame_error), 32'd0);
    send_byte(8'h00); send_byte(8'h20); send_byte(8'h77);
    cs_high();
    chk("t4b_left", 32'(exp_q.size()), 32'd0);
    chk("t4b_ferr", 32'(frame_error),  32'd0);

    // reset mid-frame, CS held low
    push(48, 8'h99);
    cs_low();
    send_byte(8'h00); send_byte(8'h30); send_byte(8'h99);
    send_bits(8'hAB, 4);
    chk("t5_first", 32'(exp_q.size()), 32'd0);
    wr0 = wr_cnt;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_bits(8'hB0, 4);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h5A);
    repeat (8) @(negedge clk);
    chk("t5_nowr", 32'(wr_cnt - wr0), 32'd0);
    chk("t5_busy", 32'(busy),         32'd0);
    cs_high();
    push(64, 8'h5A);
    cs_low();
    send_byte(8'h00); send_byte(8'h40); send_byte(8'h5A);
    cs_high();
    chk("t5_left", 32'(exp_q.size()), 32'd0);

    // write strobe latency from the eighth SCK rise
    push(80, 8'hC3);
    cs_low();
    send_byte(8'h00); send_byte(8'h50);
    send_bits(8'hC3, 7);
    spi_mosi = 1'b1;
    repeat (4) @(negedge clk);
    spi_sck = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      en_seen[k] = mem_wr_en;
    end
    chk("t6_early", 32'(en_seen[3:0]), 32'd0);
    chk("t6_at4",   32'(en_seen[4]),   32'd1);
    chk("t6_after", 32'(en_seen[5]),   32'd0);
    repeat (3) @(negedge clk);
    spi_sck = 1'b0;
    cs_high();
    chk("t6_left", 32'(exp_q.size()), 32'd0);

    // CS rise on the same sample as the completing SCK rise
    fd0 = fd_cnt;
    push(96, 8'h3C);
    cs_low();
    send_byte(8'h00); send_byte(8'h60);
    send_bits(8'h3C, 7);
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    spi_sck  = 1'b1;
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_sck = 1'b0;
    repeat (12) @(negedge clk);
    chk("t7_left", 32'(exp_q.size()), 32'd0);
    chk("t7_fd",   32'(fd_cnt - fd0), 32'd1);
    chk("t7_ferr", 32'(frame_error),  32'd0);
    chk("t7_busy", 32'(busy),         32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
